load_store_unit: RTL and testbench
==================================

# load_store_unit

Pipeline-side initiator for the byte-addressable data memory unit. Accepts one load or store request at a time from the execute/memory stage over a valid/ready handshake and performs range checking. Drives the memory unit's enable/write/address/data/width/sign controls, waits out the block-RAM read latency and captures the read data. Returns a tagged response over a second valid/ready handshake.

## Interface
- MEM_LATENCY, 1: clock edges from the enabled read cycle until the memory unit's output is valid; legal range 1–4
- MEM_BYTES, 32768: addressable bytes; accesses reaching at or beyond this address fault
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where both are high
- req_store  in  1  1 = store, 0 = load
- req_addr  in  64  byte address; misaligned addresses are allowed
- req_wdata  in  64  store data, right-aligned
- req_width  in  2  00 = byte, 01 = half, 10 = word, 11 = double
- req_signed  in  1  sign-extend load result
- req_tag  in  5  destination register index, returned unchanged
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed on an edge where both are high
- resp_rdata  out  64  load result; 0 for stores and faults
- resp_tag  out  5  tag of the request
- resp_fault  out  1  access was out of range and was not performed
- mem_en, mem_wea  out  1 each  memory enable and write enable
- mem_addr, mem_din  out  64 each  memory address and write data
- mem_bit_width  out  2  memory access width
- mem_sign_extend  out  1  memory sign-extend control
- mem_dout  in  64  memory read data, already extended by the memory unit
- busy  out  1  state is not IDLE

## Operation
- Request register: addr, wdata, width, signed, store, tag. Loaded on request acceptance. mem_addr, mem_din, mem_bit_width and mem_sign_extend are driven from this register in every state.
- Fault check at acceptance: fault if req_addr + (1 << req_width) − 1 ≥ MEM_BYTES. The sum is computed 65 bits wide so that address wrap also faults.
- States:
  - IDLE: req_ready = 1. Acceptance goes to ACCESS, or to RESP with the fault flag set if the fault check fails.
  - ACCESS: one cycle. mem_en = 1 and mem_wea = store. A store goes to RESP; a load loads the latency counter with MEM_LATENCY − 1 and goes to WAIT.
  - WAIT: mem_en = 1 and mem_wea = 0, with address held. When the counter reaches 0, capture mem_dout into resp_rdata and go to RESP; otherwise decrement the counter.
  - RESP: resp_valid = 1. resp_rdata, resp_tag and resp_fault are held stable until resp_ready is high.
    - req_ready = resp_ready in this state.
    - Response handshake with a new request in the same cycle: accept the new request and go to ACCESS or RESP (fault), exactly as from IDLE.
    - Response handshake with no new request: go to IDLE.
- A faulting request never asserts mem_en or mem_wea.
- A store has resp_rdata = 0. A load reads mem_dout unmodified.

## Timing
- Request accepted at the end of cycle 0:
  - Fault: resp_valid in cycle 1.
  - Store: ACCESS in cycle 1, write commits at the edge ending cycle 1, resp_valid in cycle 2.
  - Load: ACCESS in cycle 1, WAIT in cycles 2 to 1+MEM_LATENCY, capture at the end of cycle 1+MEM_LATENCY, resp_valid in cycle 2+MEM_LATENCY. With the default, resp_valid is in cycle 3.
- Maximum throughput with resp_ready held high: one store every 2 cycles, one load every 2+MEM_LATENCY cycles.
- Reset (asynchronous):
  - State goes to IDLE. All outputs go to 0, including mem_*, resp_*, and busy.
  - req_ready is 1 once rst_n is high.
  - Reset asserted before the edge that ends ACCESS cancels the store; no memory write occurs.
  - Reset during WAIT or RESP drops the response.
- Requests arriving while req_ready is low are ignored. The requester holds them.

## Test plan
- Double-word store 0x1122334455667788 to address 0x10, then unsigned byte load at 0x13 → resp_rdata 0x55. mem_wea is high for exactly one cycle; load resp_valid arrives 3 cycles after acceptance.
- Byte load at 0x10 with req_signed = 1 → 0xFFFFFFFFFFFFFF88; with req_signed = 0 → 0x88. resp_tag echoes 5'd17.
- Word load at 0x7FFE with MEM_BYTES = 32768 → resp_fault = 1 and rdata = 0 in cycle 1; mem_en never asserts. A double load at 0xFFFFFFFFFFFFFFFC also faults via wrap.
- Load issued with resp_ready low for 3 cycles → resp_rdata and resp_tag stay stable and req_ready stays low. When resp_ready rises with the next request valid, the new request is accepted on the same edge with no bubble.
- rst_n pulsed low during ACCESS of a store of 0xDEAD to 0x20 → all outputs 0 immediately. A later load at 0x20 returns the old contents; after reset release, req_ready is 1.
- MEM_LATENCY = 3 build: load response in cycle 5 after acceptance; mem_en is held high for 4 cycles with a constant address.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory control bundle between the
// pipeline, the load/store unit and the byte-addressable memory unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_width;
  logic        req_signed;
  logic [4:0]  req_tag;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic [4:0]  resp_tag;
  logic        resp_fault;

  logic        mem_en;
  logic        mem_wea;
  logic [63:0] mem_addr;
  logic [63:0] mem_din;
  logic [1:0]  mem_bit_width;
  logic        mem_sign_extend;
  logic [63:0] mem_dout;

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_store, req_addr, req_wdata, req_width, req_signed, req_tag,
    output req_ready,
    output resp_valid, resp_rdata, resp_tag, resp_fault,
    input  resp_ready,
    output mem_en, mem_wea, mem_addr, mem_din, mem_bit_width, mem_sign_extend,
    input  mem_dout
  );

  // The pipeline stage and memory unit surrounding it.
  modport master (
    output req_valid, req_store, req_addr, req_wdata, req_width, req_signed, req_tag,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_tag, resp_fault,
    output resp_ready,
    input  mem_en, mem_wea, mem_addr, mem_din, mem_bit_width, mem_sign_extend,
    output mem_dout
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: range-checks a request, drives the
// data memory, waits out its read latency and returns a tagged response.
module load_store_unit #(
  parameter int unsigned      MEM_LATENCY = 1,
  parameter longint unsigned  MEM_BYTES   = 64'd32768
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        req_fault;

  logic [63:0] addr_p0;
  logic [63:0] wdata_p0;
  logic [1:0]  width_p0;
  logic        signed_p0;
  logic        store_p0;
  logic [4:0]  tag_p0;

  logic [63:0] rdata_p1;
  logic        fault_p1;
  logic [1:0]  lat_cnt;

  // Last touched byte is computed one bit wider so that an address that wraps
  // past 2^64 lands above MEM_BYTES and faults instead of aliasing low memory.
  function automatic logic range_fault(input logic [63:0] addr, input logic [1:0] width);
    logic [64:0] last;
    last = {1'b0, addr} + ((65'd1 << width) - 65'd1);
    return last >= {1'b0, MEM_BYTES};
  endfunction

  assign req_fault = range_fault(bus.req_addr, bus.req_width);

  always_comb begin
    state_nxt       = state;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_wea     = 1'b0;
    case (state)
      IDLE: bus.req_ready = rst_n;
      ACCESS: begin
        bus.mem_en  = 1'b1;
        bus.mem_wea = store_p0;
        state_nxt   = store_p0 ? RESP : WAIT;
      end
      WAIT: begin
        bus.mem_en = 1'b1;
        if (lat_cnt == 2'd0) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.req_ready  = bus.resp_ready;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A new request may be taken from IDLE or on the same edge a response retires.
    accept = bus.req_ready && bus.req_valid;
    if (accept) state_nxt = req_fault ? RESP : ACCESS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- request capture (p0) and response capture (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0   <= '0;
      wdata_p0  <= '0;
      width_p0  <= '0;
      signed_p0 <= 1'b0;
      store_p0  <= 1'b0;
      tag_p0    <= '0;
      rdata_p1  <= '0;
      fault_p1  <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      if (accept) begin
        addr_p0   <= bus.req_addr;
        wdata_p0  <= bus.req_wdata;
        width_p0  <= bus.req_width;
        signed_p0 <= bus.req_signed;
        store_p0  <= bus.req_store;
        tag_p0    <= bus.req_tag;
        fault_p1  <= req_fault;
        rdata_p1  <= '0;
      end
      if (state == ACCESS && !store_p0) begin
        lat_cnt <= 2'(MEM_LATENCY - 1);
      end else if (state == WAIT && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (state == WAIT && lat_cnt == 2'd0) rdata_p1 <= bus.mem_dout;
    end
  end

  assign bus.mem_addr        = addr_p0;
  assign bus.mem_din         = wdata_p0;
  assign bus.mem_bit_width   = width_p0;
  assign bus.mem_sign_extend = signed_p0;
  assign bus.resp_rdata      = rdata_p1;
  assign bus.resp_tag        = tag_p0;
  assign bus.resp_fault      = fault_p1;
  assign busy                = (state != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two LSU builds (read latency 1 and 3) against small
// behavioural memories, with hand-computed expected responses.
module tb_load_store_unit;
  localparam longint unsigned BYTES = 64'd32768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit_if bus3 ();
  logic busy;
  logic busy3;

  load_store_unit #(.MEM_LATENCY(1), .MEM_BYTES(BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );
  load_store_unit #(.MEM_LATENCY(3), .MEM_BYTES(BYTES)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3)
  );

  // Latency-1 byte memory: little-endian, extension done on read.
  logic [7:0]  mem [0:32767];
  logic [63:0] rd_q = 64'd0;

  function automatic logic [63:0] mem_read(input logic [63:0] a, input logic [1:0] w, input logic s);
    logic [63:0] v;
    int n;
    n = 1 << w;
    v = 64'd0;
    for (int b = 0; b < 8; b++)
      if (b < n) v[8*b +: 8] = mem[15'(a + 64'(b))];
    if (s && v[8*n-1])
      for (int b = 0; b < 64; b++)
        if (b >= 8*n) v[b] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wea)
      for (int b = 0; b < 8; b++)
        if (b < (32'd1 << bus.mem_bit_width))
          mem[15'(bus.mem_addr + 64'(b))] <= bus.mem_din[8*b +: 8];
    if (bus.mem_en && !bus.mem_wea)
      rd_q <= mem_read(bus.mem_addr, bus.mem_bit_width, bus.mem_sign_extend);
  end
  assign bus.mem_dout = rd_q;

  // Latency-3 pattern memory: returns A5A5 in the top bits OR'd with the address.
  logic [63:0] p3_0 = 64'd0;
  logic [63:0] p3_1 = 64'd0;
  logic [63:0] p3_2 = 64'd0;
  always @(posedge clk) begin
    if (bus3.mem_en && !bus3.mem_wea) p3_0 <= 64'hA5A5_0000_0000_0000 | bus3.mem_addr;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign bus3.mem_dout = p3_2;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wea_cnt  = 0;
  int          en_cnt   = 0;
  int          en3_cnt  = 0;
  logic        addr3_changed = 1'b0;
  logic [63:0] addr3_last = 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to the next falling edge and record per-cycle memory activity.
  task automatic step();
    @(negedge clk);
    if (bus.mem_wea) wea_cnt++;
    if (bus.mem_en) en_cnt++;
    if (bus3.mem_en) begin
      en3_cnt++;
      if (en3_cnt > 1 && bus3.mem_addr != addr3_last) addr3_changed = 1'b1;
      addr3_last = bus3.mem_addr;
    end
  endtask

  task automatic drive_req(input logic st, input logic [63:0] a, input logic [63:0] d,
                           input logic [1:0] w, input logic s, input logic [4:0] t);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_width  = w;
    bus.req_signed = s;
    bus.req_tag    = t;
  endtask

  // Returns at the falling edge of cycle 1 (first cycle after acceptance).
  task automatic send(input logic st, input logic [63:0] a, input logic [63:0] d,
                      input logic [1:0] w, input logic s, input logic [4:0] t);
    int guard;
    guard = 0;
    drive_req(st, a, d, w, s, t);
    while (!bus.req_ready && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    step();
  endtask

  task automatic expect_resp(input string name, input logic [63:0] exp_rdata, input logic [4:0] exp_tag,
                             input logic exp_fault, input int exp_cyc);
    int cyc;
    cyc = 1;
    while (!bus.resp_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({name, "_lat"},   64'(cyc), 64'(exp_cyc));
    check({name, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({name, "_tag"},   64'(bus.resp_tag), 64'(exp_tag));
    check({name, "_fault"}, 64'(bus.resp_fault), 64'(exp_fault));
  endtask

  task automatic xact(input string name, input logic st, input logic [63:0] a, input logic [63:0] d,
                      input logic [1:0] w, input logic s, input logic [4:0] t,
                      input logic [63:0] exp_rdata, input logic exp_fault, input int exp_cyc);
    send(st, a, d, w, s, t);
    expect_resp(name, exp_rdata, t, exp_fault, exp_cyc);
    step();
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    bus.req_valid = 1'b0;  bus.req_store = 1'b0;  bus.req_addr = 64'd0;  bus.req_wdata = 64'd0;
    bus.req_width = 2'd0;  bus.req_signed = 1'b0; bus.req_tag = 5'd0;    bus.resp_ready = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_store = 1'b0; bus3.req_addr = 64'd0; bus3.req_wdata = 64'd0;
    bus3.req_width = 2'd0; bus3.req_signed = 1'b0; bus3.req_tag = 5'd0;  bus3.resp_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_req_ready",  64'(bus.req_ready), 64'd0);
    check("rst_busy",       64'(busy), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_mem_en",     64'(bus.mem_en), 64'd0);
    rst_n = 1'b1;
    #1 check("rel_req_ready", 64'(bus.req_ready), 64'd1);
    step();

    // Double store then unsigned byte load from inside it
    wea_cnt = 0;
    xact("st_d", 1'b1, 64'h10, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 5'd1, 64'd0, 1'b0, 2);
    check("st_wea_cycles", 64'(wea_cnt), 64'd1);
    xact("ld_b", 1'b0, 64'h13, 64'd0, 2'd0, 1'b0, 5'd2, 64'h55, 1'b0, 3);

    // Sign extension on byte loads, tag echo
    xact("ld_bs", 1'b0, 64'h10, 64'd0, 2'd0, 1'b1, 5'd17, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 3);
    xact("ld_bu", 1'b0, 64'h10, 64'd0, 2'd0, 1'b0, 5'd17, 64'h88, 1'b0, 3);

    // Range faults: straddling the top, and 64-bit wrap; memory never enabled
    en_cnt = 0;
    xact("flt_w",    1'b0, 64'h7FFE, 64'd0, 2'd2, 1'b0, 5'd3, 64'd0, 1'b1, 1);
    xact("flt_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 2'd3, 1'b0, 5'd4, 64'd0, 1'b1, 1);
    check("flt_no_en", 64'(en_cnt), 64'd0);

    // Last legal word
    xact("edge_st", 1'b1, 64'h7FFC, 64'hA1B2_C3D4, 2'd2, 1'b0, 5'd5, 64'd0, 1'b0, 2);
    xact("edge_ld", 1'b0, 64'h7FFC, 64'd0, 2'd2, 1'b1, 5'd6, 64'hFFFF_FFFF_A1B2_C3D4, 1'b0, 3);

    // Response backpressure with a pending request, then same-edge handover
    bus.resp_ready = 1'b0;
    send(1'b0, 64'h10, 64'd0, 2'd1, 1'b0, 5'd7);
    expect_resp("bp", 64'h7788, 5'd7, 1'b0, 3);
    drive_req(1'b0, 64'h12, 64'd0, 2'd1, 1'b1, 5'd8);
    for (int i = 0; i < 3; i++) begin
      check("bp_rdata_hold", bus.resp_rdata, 64'h7788);
      check("bp_tag_hold",   64'(bus.resp_tag), 64'd7);
      check("bp_req_ready",  64'(bus.req_ready), 64'd0);
      step();
    end
    check("bp_valid_hold", 64'(bus.resp_valid), 64'd1);
    bus.resp_ready = 1'b1;
    #1 check("bp_req_ready_up", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    step();
    check("bp_nobubble_en", 64'(bus.mem_en), 64'd1);
    check("bp_nobubble_rv", 64'(bus.resp_valid), 64'd0);
    expect_resp("bp_next", 64'h5566, 5'd8, 1'b0, 3);
    step();

    // Reset during the ACCESS cycle of a store cancels the write
    xact("st_old", 1'b1, 64'h20, 64'hCAFE, 2'd3, 1'b0, 5'd9, 64'd0, 1'b0, 2);
    drive_req(1'b1, 64'h20, 64'hDEAD, 2'd3, 1'b0, 5'd10);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #1 check("rs_in_access", 64'(bus.mem_wea), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rs_mem_en",     64'(bus.mem_en), 64'd0);
    check("rs_mem_wea",    64'(bus.mem_wea), 64'd0);
    check("rs_mem_addr",   bus.mem_addr, 64'd0);
    check("rs_mem_din",    bus.mem_din, 64'd0);
    check("rs_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rs_resp_tag",   64'(bus.resp_tag), 64'd0);
    check("rs_busy",       64'(busy), 64'd0);
    check("rs_req_ready",  64'(bus.req_ready), 64'd0);
    step();
    rst_n = 1'b1;
    #1 check("rs_rel_req_ready", 64'(bus.req_ready), 64'd1);
    step();
    xact("ld_old", 1'b0, 64'h20, 64'd0, 2'd3, 1'b0, 5'd11, 64'hCAFE, 1'b0, 3);

    // Latency-3 build: response in cycle 5, enable held 4 cycles on one address
    en3_cnt = 0;
    addr3_changed = 1'b0;
    bus3.req_valid = 1'b1;  bus3.req_store = 1'b0; bus3.req_addr = 64'h40;
    bus3.req_width = 2'd3;  bus3.req_signed = 1'b0; bus3.req_tag = 5'd12;
    @(posedge clk);
    #1 bus3.req_valid = 1'b0;
    step();
    cyc = 1;
    while (!bus3.resp_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("l3_lat",       64'(cyc), 64'd5);
    check("l3_rdata",     bus3.resp_rdata, 64'hA5A5_0000_0000_0040);
    check("l3_tag",       64'(bus3.resp_tag), 64'd12);
    check("l3_busy",      64'(busy3), 64'd1);
    check("l3_en_cycles", 64'(en3_cnt), 64'd4);
    check("l3_addr_held", 64'(addr3_changed), 64'd0);
    check("l3_addr",      addr3_last, 64'h40);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
